// File: rtl/stack_sequencer_pkg.sv
// stack_sequencer_pkg
//   Shared definitions for the stack sequencer:
//   - op_code values decoded by the sequencer (PUSH, POP, CALL, RET)
//   - FSM state encoding (also exported on the debug state port)
//   - WORD_BYTES, the size of one stack slot
//   - small helpers that classify an op_code
package stack_sequencer_pkg;

  localparam logic [31:0] WORD_BYTES = 32'd4;

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_CALL = 2'b10;
  localparam logic [1:0] OP_RET  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADJ  = 2'd1,
    ST_MEM  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  // PUSH and CALL grow the stack: decrement ESP first, then write the slot.
  function automatic logic pushes_word(input logic [1:0] op);
    return (op == OP_PUSH) || (op == OP_CALL);
  endfunction

  // CALL and RET redirect the instruction pointer on completion.
  function automatic logic loads_eip(input logic [1:0] op);
    return (op == OP_CALL) || (op == OP_RET);
  endfunction

endpackage

// File: rtl/stack_sequencer_if.sv
// stack_sequencer_if
//   Bundles every non-clock signal of the stack sequencer:
//   decoder op handshake (op_*), ESP register port (esp, esp_wr, esp_next),
//   data-memory port (mem_*), and completion reporting (done, fault,
//   pop_data, eip_load, eip_value).
//   modport slave  : the sequencer itself
//   modport master : the surrounding core (decoder, ESP register, memory)
//
// Handshake semantics:
//   op:  an op transfers on a cycle where op_valid && op_ready; op_code,
//        op_data, op_target and esp are sampled on that edge only.
//   mem: mem_req is held, with mem_we/mem_addr/mem_wdata stable, until a
//        cycle with mem_ack=1; that cycle completes the access and
//        mem_rdata is sampled on it for reads.
interface stack_sequencer_if;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] op_data;
  logic [31:0] op_target;
  logic        op_ready;
  logic [31:0] esp;
  logic        esp_wr;
  logic [31:0] esp_next;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        done;
  logic        fault;
  logic [31:0] pop_data;
  logic        eip_load;
  logic [31:0] eip_value;

  modport slave (
    input  op_valid, op_code, op_data, op_target, esp, mem_ack, mem_rdata,
    output op_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr, mem_wdata,
           done, fault, pop_data, eip_load, eip_value
  );

  modport master (
    output op_valid, op_code, op_data, op_target, esp, mem_ack, mem_rdata,
    input  op_ready, esp_wr, esp_next, mem_req, mem_we, mem_addr, mem_wdata,
           done, fault, pop_data, eip_load, eip_value
  );
endinterface

// File: rtl/stack_bounds_check.sv
// stack_bounds_check
//   Combinational stack bounds check for one op.
//   Ports:
//     esp        in  32  ESP value the op would start from
//     op_code    in   2  stack op
//     fault_cond out  1  1 = op must be rejected
//   A push-type op needs a whole free slot at or above STACK_LIMIT; a
//   pop-type op needs ESP strictly below STACK_TOP. Compares are unsigned,
//   so a small ESP never wraps into a legal value.
module stack_bounds_check
  import stack_sequencer_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0000
) (
  input  logic [31:0] esp,
  input  logic [1:0]  op_code,
  output logic        fault_cond
);

  always_comb begin
    fault_cond = 1'b0;
    if (pushes_word(op_code)) begin
      fault_cond = (esp < (STACK_LIMIT + WORD_BYTES));
    end else begin
      fault_cond = (esp >= STACK_TOP);
    end
  end

endmodule

// File: rtl/stack_sequencer.sv
// stack_sequencer
//   Sequences the ESP update and memory access of PUSH, POP, CALL and RET,
//   and rejects ops that would leave the stack bounds.
//   Ports:
//     clk       in   system clock, all state on posedge
//     rst_n     in   asynchronous active-low reset
//     bus       slave side of stack_sequencer_if (op, ESP, memory, results)
//     dbg_state out  current FSM state
//   Flow (cycle 0 = accept):
//     PUSH/CALL: IDLE -> ADJ (esp_wr) -> MEM (write, until ack) -> FIN
//     POP/RET  : IDLE -> MEM (read, until ack) -> ADJ (esp_wr) -> FIN
//     fault    : IDLE -> FIN with fault=1
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = 32'h0000_1000,
  parameter logic [31:0] STACK_LIMIT = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  stack_sequencer_if.slave bus,
  output state_e           dbg_state
);

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] data_q, data_d;
  logic [31:0] target_q, target_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pop_data_q, pop_data_d;
  logic        fault_q, fault_d;

  logic fault_cond;
  logic op_ready_w;
  logic accept;
  logic esp_wr_w;
  logic mem_req_w;
  logic mem_we_w;
  logic fin_w;
  logic eip_load_w;

  stack_bounds_check #(
    .STACK_TOP  (STACK_TOP),
    .STACK_LIMIT(STACK_LIMIT)
  ) u_bounds (
    .esp       (bus.esp),
    .op_code   (bus.op_code),
    .fault_cond(fault_cond)
  );

  // ready_q keeps op_ready low until the first edge after reset release.
  assign op_ready_w = ready_q && (state_q == ST_IDLE);
  assign accept     = bus.op_valid && op_ready_w;

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b1;
    op_d       = op_q;
    data_d     = data_q;
    target_d   = target_q;
    addr_d     = addr_q;
    pop_data_d = pop_data_q;
    fault_d    = fault_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d     = bus.op_code;
          data_d   = bus.op_data;
          target_d = bus.op_target;
          fault_d  = fault_cond;
          // addr_q is the slot touched; the new ESP is derived from it.
          addr_d   = pushes_word(bus.op_code) ? (bus.esp - WORD_BYTES) : bus.esp;
          if (fault_cond) begin
            state_d = ST_FIN;
          end else if (pushes_word(bus.op_code)) begin
            state_d = ST_ADJ;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_ADJ: begin
        state_d = pushes_word(op_q) ? ST_MEM : ST_FIN;
      end
      ST_MEM: begin
        if (bus.mem_ack) begin
          if (!pushes_word(op_q)) begin
            pop_data_d = bus.mem_rdata;
          end
          state_d = pushes_word(op_q) ? ST_FIN : ST_ADJ;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ready_q    <= 1'b0;
      op_q       <= OP_PUSH;
      data_q     <= '0;
      target_q   <= '0;
      addr_q     <= '0;
      pop_data_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_q    <= ready_d;
      op_q       <= op_d;
      data_q     <= data_d;
      target_q   <= target_d;
      addr_q     <= addr_d;
      pop_data_q <= pop_data_d;
      fault_q    <= fault_d;
    end
  end

  // Outputs decode directly from state_q so reset clears them at once.
  assign esp_wr_w   = (state_q == ST_ADJ);
  assign mem_req_w  = (state_q == ST_MEM);
  assign mem_we_w   = mem_req_w && pushes_word(op_q);
  assign fin_w      = (state_q == ST_FIN);
  assign eip_load_w = fin_w && !fault_q && loads_eip(op_q);

  assign bus.op_ready  = op_ready_w;
  assign bus.esp_wr    = esp_wr_w;
  assign bus.esp_next  = !esp_wr_w ? '0 :
                         pushes_word(op_q) ? addr_q : (addr_q + WORD_BYTES);
  assign bus.mem_req   = mem_req_w;
  assign bus.mem_we    = mem_we_w;
  assign bus.mem_addr  = mem_req_w ? addr_q : '0;
  assign bus.mem_wdata = mem_we_w ? data_q : '0;
  assign bus.done      = fin_w;
  assign bus.fault     = fin_w && fault_q;
  assign bus.pop_data  = pop_data_q;
  assign bus.eip_load  = eip_load_w;
  assign bus.eip_value = !eip_load_w ? '0 :
                         (op_q == OP_CALL) ? target_q : pop_data_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// tb_stack_sequencer
//   Self-checking bench for stack_sequencer: directed vector table,
//   hand-written multi-cycle sequences (back-to-back, reset mid-op) and a
//   randomized run checked against a stack-level reference model.
module tb_stack_sequencer;
  import stack_sequencer_pkg::*;

  localparam logic [31:0] STACK_TOP   = 32'h0000_1000;
  localparam logic [31:0] STACK_LIMIT = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst_n;
  state_e dbg_state;

  always #5 clk = ~clk;

  stack_sequencer_if bus();

  stack_sequencer #(
    .STACK_TOP  (STACK_TOP),
    .STACK_LIMIT(STACK_LIMIT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [31:0] target;
    logic [31:0] esp;
    int          delay;
    logic [31:0] rdata;      // nonzero: preload memory at esp for a read
    int          e_done;
    int          e_wr_cyc;   // 0 = no esp_wr expected
    logic [31:0] e_next;
    int          e_req_first;
    int          e_req_n;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wdata;
    logic        e_fault;
    logic        e_eip_load;
    logic [31:0] e_eip;
    logic [31:0] e_pop;
  } vec_t;

  typedef struct {
    int          done_cyc;
    int          wr_n;
    int          wr_cyc;
    logic [31:0] next;
    int          req_first;
    int          req_n;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    int          unstable;
    logic        fault;
    logic        eip_load;
    logic [31:0] eip;
    logic [31:0] pop;
    int          ready_busy;
    int          overlap;
    logic        ready_acc;
    logic        ready_after;
  } obs_t;

  // Bench-side ESP register and data memory, driven by the DUT strobes.
  logic [31:0] esp_reg;
  logic [31:0] tb_mem [logic [31:0]];
  int          cur_delay;
  int          req_k;

  // Reference model state.
  logic [31:0] model_mem [logic [31:0]];
  logic [31:0] model_esp;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] fill(logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] rd_tb(logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : fill(a);
  endfunction

  // Stack semantics with fixed latencies: growth writes the new top slot,
  // shrink reads the current top slot; out-of-range ops fault at once.
  function automatic vec_t model_op(vec_t v);
    vec_t        r;
    logic        grow;
    logic [31:0] slot;
    logic [31:0] val;
    r = v;
    grow = (v.op == OP_PUSH) || (v.op == OP_CALL);
    r.e_fault = grow ? (v.esp < STACK_LIMIT + 32'd4) : (v.esp >= STACK_TOP);
    r.e_wr_cyc = 0; r.e_next = '0; r.e_req_first = 0; r.e_req_n = 0;
    r.e_addr = '0; r.e_we = 1'b0; r.e_wdata = '0;
    r.e_eip_load = 1'b0; r.e_eip = '0; r.e_pop = '0;
    if (r.e_fault) begin
      r.e_done = 1;
    end else if (grow) begin
      slot = v.esp - 32'd4;
      model_mem[slot] = v.data;
      model_esp = slot;
      r.e_wr_cyc = 1; r.e_next = slot;
      r.e_req_first = 2; r.e_req_n = v.delay + 1;
      r.e_addr = slot; r.e_we = 1'b1; r.e_wdata = v.data;
      r.e_done = 3 + v.delay;
      r.e_eip_load = (v.op == OP_CALL); r.e_eip = v.target;
    end else begin
      val = model_mem.exists(v.esp) ? model_mem[v.esp] : fill(v.esp);
      model_esp = v.esp + 32'd4;
      r.e_req_first = 1; r.e_req_n = v.delay + 1;
      r.e_addr = v.esp; r.e_we = 1'b0;
      r.e_wr_cyc = 2 + v.delay; r.e_next = v.esp + 32'd4;
      r.e_done = 3 + v.delay;
      r.e_pop = val;
      r.e_eip_load = (v.op == OP_RET); r.e_eip = val;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Called once per negedge: memory and ESP register responses.
  task automatic service();
    if (bus.esp_wr) esp_reg = bus.esp_next;
    bus.esp = esp_reg;
    if (bus.mem_req) begin
      req_k++;
      if (req_k > cur_delay) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rd_tb(bus.mem_addr);
        if (bus.mem_we) tb_mem[bus.mem_addr] = bus.mem_wdata;
        req_k = 0;
      end else begin
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hBAD0_BAD0;
      end
    end else begin
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = 32'hBAD0_BAD0;
      req_k = 0;
    end
  endtask

  task automatic run_op(input vec_t v, output obs_t o);
    o = '{default: 0};
    o.done_cyc = -1;
    cur_delay = v.delay;
    req_k = 0;
    @(negedge clk);
    bus.op_valid  = 1'b1;
    bus.op_code   = v.op;
    bus.op_data   = v.data;
    bus.op_target = v.target;
    bus.esp       = esp_reg;
    o.ready_acc   = bus.op_ready;
    @(posedge clk);
    for (int c = 1; c <= 40 && o.done_cyc < 0; c++) begin
      @(negedge clk);
      bus.op_valid = 1'b0;
      if (bus.op_ready) o.ready_busy++;
      if (bus.esp_wr) begin
        o.wr_n++; o.wr_cyc = c; o.next = bus.esp_next;
      end
      if (bus.esp_wr && bus.mem_req) o.overlap++;
      if (bus.mem_req) begin
        if (o.req_n == 0) begin
          o.req_first = c; o.addr = bus.mem_addr;
          o.we = bus.mem_we; o.wdata = bus.mem_wdata;
        end else if (bus.mem_addr !== o.addr || bus.mem_we !== o.we ||
                     bus.mem_wdata !== o.wdata) begin
          o.unstable++;
        end
        o.req_n++;
      end
      if (bus.done) begin
        o.done_cyc = c; o.fault = bus.fault; o.eip_load = bus.eip_load;
        o.eip = bus.eip_value; o.pop = bus.pop_data;
      end
      service();
    end
    @(negedge clk);
    o.ready_after = bus.op_ready;
    service();
  endtask

  task automatic check_obs(string tag, vec_t v, obs_t o);
    chk({tag, " ready_at_accept"}, o.ready_acc, 1);
    chk({tag, " done_cycle"}, o.done_cyc, v.e_done);
    chk({tag, " fault"}, o.fault, v.e_fault);
    chk({tag, " esp_wr_count"}, o.wr_n, (v.e_wr_cyc != 0) ? 1 : 0);
    chk({tag, " esp_wr_cycle"}, o.wr_cyc, v.e_wr_cyc);
    if (v.e_wr_cyc != 0) chk({tag, " esp_next"}, o.next, v.e_next);
    chk({tag, " mem_req_cycles"}, o.req_n, v.e_req_n);
    if (v.e_req_n != 0) begin
      chk({tag, " mem_req_first"}, o.req_first, v.e_req_first);
      chk({tag, " mem_addr"}, o.addr, v.e_addr);
      chk({tag, " mem_we"}, o.we, v.e_we);
      chk({tag, " mem_stable"}, o.unstable, 0);
    end
    if (v.e_req_n != 0 && v.e_we) chk({tag, " mem_wdata"}, o.wdata, v.e_wdata);
    chk({tag, " eip_load"}, o.eip_load, v.e_eip_load);
    if (v.e_eip_load) chk({tag, " eip_value"}, o.eip, v.e_eip);
    if (!v.e_fault && !pushes_word(v.op)) chk({tag, " pop_data"}, o.pop, v.e_pop);
    chk({tag, " ready_while_busy"}, o.ready_busy, 0);
    chk({tag, " wr_req_overlap"}, o.overlap, 0);
    chk({tag, " ready_after_done"}, o.ready_after, 1);
  endtask

  // ---------------- stimulus ----------------
  vec_t tbl[12];

  initial begin
    obs_t o;
    vec_t v;
    int   acc[2];
    int   dn[2];
    int   na, nd, ov;

    rst_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = OP_PUSH; bus.op_data = '0;
    bus.op_target = '0; bus.esp = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    esp_reg = STACK_TOP; cur_delay = 0; req_k = 0; model_esp = STACK_TOP;

    //            op       data          target      esp           dly rdata
    //            done wr next         rqf rqn addr          we wdata         flt eipl eip           pop
    tbl[0]  = '{OP_PUSH, 32'hDEADBEEF, 32'h0,      32'h0000_1000, 0, 32'h0,
                3, 1, 32'h0000_0FFC, 2, 1, 32'h0000_0FFC, 1, 32'hDEADBEEF, 0, 0, 32'h0, 32'h0};
    tbl[1]  = '{OP_POP,  32'h0,        32'h0,      32'h0000_0FFC, 2, 32'h12345678,
                5, 4, 32'h0000_1000, 1, 3, 32'h0000_0FFC, 0, 32'h0, 0, 0, 32'h0, 32'h12345678};
    tbl[2]  = '{OP_CALL, 32'h40,       32'h200,    32'h0000_0800, 0, 32'h0,
                3, 1, 32'h0000_07FC, 2, 1, 32'h0000_07FC, 1, 32'h40, 0, 1, 32'h200, 32'h0};
    tbl[3]  = '{OP_RET,  32'h0,        32'h0,      32'h0000_07FC, 0, 32'h0,
                3, 2, 32'h0000_0800, 1, 1, 32'h0000_07FC, 0, 32'h0, 0, 1, 32'h40, 32'h40};
    tbl[4]  = '{OP_POP,  32'h0,        32'h0,      32'h0000_1000, 0, 32'h0,
                1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    tbl[5]  = '{OP_PUSH, 32'h55,       32'h0,      32'h0000_0000, 0, 32'h0,
                1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    tbl[6]  = '{OP_PUSH, 32'h55,       32'h0,      32'h0000_0003, 0, 32'h0,
                1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    tbl[7]  = '{OP_PUSH, 32'hA1,       32'h0,      32'h0000_0004, 1, 32'h0,
                4, 1, 32'h0000_0000, 2, 2, 32'h0000_0000, 1, 32'hA1, 0, 0, 32'h0, 32'h0};
    tbl[8]  = '{OP_RET,  32'h0,        32'h0,      32'h0000_0FFC, 1, 32'h300,
                4, 3, 32'h0000_1000, 1, 2, 32'h0000_0FFC, 0, 32'h0, 0, 1, 32'h300, 32'h300};
    tbl[9]  = '{OP_POP,  32'h0,        32'h0,      32'hFFFF_FFFC, 0, 32'h0,
                1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    tbl[10] = '{OP_CALL, 32'h10,       32'h20,     32'h0000_0002, 0, 32'h0,
                1, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 1, 0, 32'h0, 32'h0};
    tbl[11] = '{OP_POP,  32'h0,        32'h0,      32'h0000_0000, 3, 32'h77,
                6, 5, 32'h0000_0004, 1, 4, 32'h0000_0000, 0, 32'h0, 0, 0, 32'h0, 32'h77};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst esp_wr", bus.esp_wr, 0);
    chk("rst esp_next", bus.esp_next, 0);
    chk("rst mem_req", bus.mem_req, 0);
    chk("rst mem_addr", bus.mem_addr, 0);
    chk("rst mem_wdata", bus.mem_wdata, 0);
    chk("rst done", bus.done, 0);
    chk("rst fault", bus.fault, 0);
    chk("rst pop_data", bus.pop_data, 0);
    chk("rst eip_load", bus.eip_load, 0);
    chk("rst eip_value", bus.eip_value, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst op_ready_after_release", bus.op_ready, 1);
    chk("rst state_idle", 32'(dbg_state), 32'(ST_IDLE));

    // Directed vector table.
    for (int i = 0; i < 12; i++) begin
      esp_reg = tbl[i].esp;
      if (tbl[i].rdata != 0) tb_mem[tbl[i].esp] = tbl[i].rdata;
      run_op(tbl[i], o);
      check_obs($sformatf("vec%0d", i), tbl[i], o);
    end

    // Back-to-back: op_valid held high, PUSH then POP.
    esp_reg = 32'h0000_0800; cur_delay = 0; req_k = 0;
    acc[0] = -1; acc[1] = -1; dn[0] = -1; dn[1] = -1; na = 0; nd = 0; ov = 0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = OP_PUSH; bus.op_data = 32'hCAFE_F00D;
    bus.esp = esp_reg;
    for (int c = 0; c < 30 && nd < 2; c++) begin
      if (c > 0) @(negedge clk);
      if (na == 2) bus.op_valid = 1'b0;
      if (bus.op_valid && bus.op_ready && na < 2) begin
        acc[na] = c; na++;
      end
      if (bus.esp_wr && bus.mem_req) ov++;
      if (bus.done) begin
        dn[nd] = c; nd++; bus.op_code = OP_POP;
      end
      service();
    end
    bus.op_valid = 1'b0;
    chk("b2b accept1", acc[0], 0);
    chk("b2b done1", dn[0], 3);
    chk("b2b accept2", acc[1], 4);
    chk("b2b done2", dn[1], 7);
    chk("b2b overlap", ov, 0);
    chk("b2b pop_data", bus.pop_data, 32'hCAFE_F00D);
    chk("b2b esp_final", esp_reg, 32'h0000_0800);

    // Reset while a PUSH waits in MEM.
    esp_reg = 32'h0000_0800; cur_delay = 100; req_k = 0;
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op_code = OP_PUSH; bus.op_data = 32'h5A5A_0001;
    bus.esp = esp_reg;
    @(posedge clk);
    @(negedge clk); bus.op_valid = 1'b0; service();
    @(negedge clk);
    chk("rstmid mem_req_before", bus.mem_req, 1);
    chk("rstmid state_mem", 32'(dbg_state), 32'(ST_MEM));
    service();
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid mem_req", bus.mem_req, 0);
    chk("rstmid done", bus.done, 0);
    chk("rstmid esp_wr", bus.esp_wr, 0);
    chk("rstmid state_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("rstmid esp_decremented", esp_reg, 32'h0000_07FC);
    bus.mem_ack = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstmid op_ready", bus.op_ready, 1);

    // Randomized run against the reference model, near both bounds.
    tb_mem.delete();
    model_mem.delete();
    for (int ph = 0; ph < 2; ph++) begin
      esp_reg   = (ph == 0) ? 32'h0000_0FF4 : 32'h0000_0008;
      model_esp = esp_reg;
      for (int k = 0; k < 40; k++) begin
        v.op     = 2'($urandom_range(0, 3));
        v.data   = $urandom;
        v.target = $urandom;
        v.delay  = $urandom_range(0, 3);
        v.rdata  = '0;
        v.esp    = model_esp;
        v = model_op(v);
        run_op(v, o);
        check_obs($sformatf("rnd%0d_%0d", ph, k), v, o);
        chk($sformatf("rnd%0d_%0d esp_reg", ph, k), esp_reg, model_esp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_sequencer.md
# stack_sequencer

Multi-cycle controller that sequences every stack-pointer (ESP) update and its matching memory access for PUSH, POP, CALL and RET. It sits between the instruction decoder and the ESP register / data-memory port. It is the single agent allowed to write ESP or to touch memory on behalf of stack instructions. It also enforces stack bounds and reports faults instead of corrupting ESP.

## Interface
- STACK_TOP, 32'h0000_1000, ESP value of an empty stack; POP/RET fault when esp >= STACK_TOP
- STACK_LIMIT, 32'h0000_0000, lowest legal slot address; PUSH/CALL fault when esp < STACK_LIMIT + 4
- clock  in  1  single system clock, all state on posedge
- reset  in  1  asynchronous, active-low; clears all state and outputs immediately
- op_valid  in  1  decoder presents a stack op
- op_code  in  2  00 PUSH, 01 POP, 10 CALL, 11 RET
- op_data  in  32  PUSH data / CALL return address
- op_target  in  32  CALL destination
- op_ready  out  1  high only in IDLE; accept = op_valid & op_ready
- esp  in  32  current ESP register value
- esp_wr  out  1  one-cycle write strobe to ESP register
- esp_next  out  32  value written when esp_wr=1
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  1 write, 0 read; valid with mem_req
- mem_addr  out  32  byte address, valid with mem_req
- mem_wdata  out  32  write data
- mem_ack  in  1  completes the request in the same cycle
- mem_rdata  in  32  read data, valid with mem_ack
- done  out  1  one-cycle completion pulse
- fault  out  1  with done: op rejected by bounds check
- pop_data  out  32  value popped (POP/RET), held until next accept
- eip_load  out  1  with done: load eip_value (CALL/RET only)
- eip_value  out  32  CALL: op_target; RET: popped value

## Operation
- States: IDLE, ADJ, MEM, FIN. Ops, operands and esp are latched on accept.
- PUSH/CALL: IDLE→ADJ (esp_wr, esp_next=esp-4, addr latched = esp-4)→MEM (mem_req, mem_we=1, mem_wdata=op_data) until mem_ack→FIN.
- POP/RET: IDLE→MEM (mem_req, mem_we=0, addr=esp) until mem_ack; pop_data latched from mem_rdata→ADJ (esp_wr, esp_next=esp+4)→FIN.
- FIN: done=1; eip_load=1 for CALL/RET; →IDLE.
- Bounds are checked on the latched esp at accept. If the check fails: IDLE→FIN with fault=1, no esp_wr, no mem_req, eip_load=0.
- Arithmetic is 32-bit modulo. The bounds check uses unsigned compare, so esp < 4 with STACK_LIMIT=0 faults and does not wrap.
- ESP is written exactly once per non-faulting op and never during MEM.
- The esp input is ignored outside the accept cycle.

## Timing
- Reset values: op_ready=1 once reset is released; every other output is 0; state=IDLE.
- Zero-wait memory, i.e. mem_ack in the first mem_req cycle (accept = cycle 0):
  - PUSH: esp_wr in cycle 1, mem_req in cycle 2, done in cycle 3.
  - POP: mem_req in cycle 1, esp_wr in cycle 2, done in cycle 3.
- Each wait cycle on mem_ack adds one cycle. mem_addr, mem_we and mem_wdata stay stable while mem_req=1.
- Faulting op: done+fault in cycle 1.
- op_ready is 0 from the cycle after accept through FIN. The next accept is possible one cycle after done.
- Reset asserted mid-op (any state) clears immediately to IDLE. mem_req drops asynchronously. A PUSH already past ADJ leaves ESP decremented; this is accepted, since reset re-initialises ESP anyway.

## Structure
- A shared package holds the op_code constants (OP_PUSH, OP_POP, OP_CALL, OP_RET), the state encoding, and WORD_BYTES=4.
- One combinational sub-module, stack_bounds_check: inputs esp and op_code, output fault_cond. Parameters STACK_TOP and STACK_LIMIT are passed down to it.

## Test plan
- PUSH: esp=0x1000, op_data=0xDEADBEEF, zero-wait ack → esp_wr with esp_next=0x0FFC in cycle 1; write to 0x0FFC with 0xDEADBEEF in cycle 2; done in cycle 3; fault=0.
- POP: esp=0x0FFC, mem_rdata=0x12345678, ack delayed 2 cycles → read of 0x0FFC held 3 cycles; pop_data=0x12345678; esp_next=0x1000; done 5 cycles after accept.
- CALL: esp=0x0800, op_data=0x40, op_target=0x200 → write 0x40 to 0x07FC; done with eip_load=1, eip_value=0x200. RET then pops 0x40 → eip_value=0x40, esp_next=0x0800.
- Faults:
  - POP with esp=0x1000 → done+fault in cycle 1; no mem_req, no esp_wr.
  - PUSH with esp=0x0000 → same response.
- Reset in MEM with mem_req=1 → mem_req, done and esp_wr read 0 immediately; op_ready=1 on the first clock edge after reset is released.
- Back-to-back: op_valid held high for PUSH then POP → second accept in the cycle after the first done; no overlapping esp_wr or mem_req.
